// File: rtl/uart_rx_frame_receiver.sv
// UART receive path: 3-sample majority voting per bit, LSB-first data, optional parity, stop check.
// Optional macro UART_RX_INPUT_SYNC_EN adds a 2-flop synchronizer on RX_IN (adds 2 cycles of latency).
module uart_rx_frame_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] EDGE_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] SMP0      = CNT_W'(PRESCALE / 2 - 1);
  localparam logic [CNT_W-1:0] SMP1      = CNT_W'(PRESCALE / 2);
  localparam logic [CNT_W-1:0] SMP2      = CNT_W'(PRESCALE / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_par(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  state_t                  state, state_nxt;
  logic                    rx;
  logic [CNT_W-1:0]        edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    smp_p0, smp_p1;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_en_q, par_typ_q, par_bad, start_bad;
  logic                    edge_last, maj_cyc, maj_bit, frame_done, frame_ok;

`ifdef UART_RX_INPUT_SYNC_EN
  logic rx_p0, rx_p1;
  // Two-flop synchronizer, resets to the idle line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= RX_IN;
      rx_p1 <= rx_p0;
    end
  end
  assign rx = rx_p1;
`else
  assign rx = RX_IN;
`endif

  assign edge_last = (edge_cnt == EDGE_LAST);
  assign maj_cyc   = (edge_cnt == SMP2);
  assign maj_bit   = maj3(smp_p0, smp_p1, rx);
  assign frame_ok  = !par_bad && maj_bit;

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (!rx) state_nxt = START;
      START:  if (edge_last) state_nxt = start_bad ? IDLE : DATA;
      DATA:   if (edge_last && bit_cnt == BIT_LAST) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (edge_last) state_nxt = STOP;
      STOP: begin
        // Leave half a bit early so a following start edge is not missed
        if (maj_cyc) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      start_bad  <= 1'b0;
      par_bad    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      P_DATA     <= '0;
    end else begin
      state      <= state_nxt;
      Data_Valid <= frame_done && frame_ok;
      par_err    <= frame_done && par_bad;
      stp_err    <= frame_done && !maj_bit;
      if (frame_done && frame_ok) P_DATA <= shift_reg;
      // The cycle that detects the start edge is edge 0 of the start bit
      if (state == IDLE)                      edge_cnt <= rx ? '0 : EDGE_ONE;
      else if (edge_last || state_nxt == IDLE) edge_cnt <= '0;
      else                                    edge_cnt <= edge_cnt + EDGE_ONE;
      case (state)
        IDLE: begin
          if (!rx) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad   <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START:  if (maj_cyc) start_bad <= maj_bit;
        DATA:   if (edge_last) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
        PARITY: if (maj_cyc) par_bad <= (maj_bit != exp_par(shift_reg, par_typ_q));
        default: ;
      endcase
    end
  end

  // Sample stage: two registered votes, shift register fed LSB first
  always_ff @(posedge clk) begin
    if (edge_cnt == SMP0) smp_p0 <= rx;
    if (edge_cnt == SMP1) smp_p1 <= rx;
    if (state == DATA && maj_cyc) shift_reg <= {maj_bit, shift_reg[DATA_WIDTH-1:1]};
  end

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Bench for uart_rx_frame_receiver: directed + random frames, checked against a frame-level model.
module tb_uart_rx_frame_receiver;
  localparam int DW   = 8;
  localparam int P    = 8;
  localparam int MAXC = 9000;
`ifdef UART_RX_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1, rx = 1'b1, pen = 1'b0, ptyp = 1'b0;
  logic [DW-1:0] pdata;
  logic          dv, pe, se;

  uart_rx_frame_receiver #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .RX_IN(rx), .PAR_EN(pen), .PAR_TYP(ptyp),
    .P_DATA(pdata), .Data_Valid(dv), .par_err(pe), .stp_err(se)
  );

  always #5 clk = ~clk;

  // Per-posedge stimulus waveform and expected outputs after that posedge
  bit            w_line[MAXC], w_rst[MAXC], w_pen[MAXC], w_ptyp[MAXC];
  bit            e_dv[MAXC], e_pe[MAXC], e_se[MAXC];
  logic [DW-1:0] e_dat[MAXC], e_pd[MAXC];
  int            len = 0;
  int            m_events = 0;
  int            checks = 0, errors = 0;
  int            q_cyc[$];
  logic [2:0]    q_kind[$];
  logic [DW-1:0] q_pd[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit l, input bit r, input bit p, input bit t);
    if (len < MAXC) begin
      w_line[len] = l; w_rst[len] = r; w_pen[len] = p; w_ptyp[len] = t;
      len++;
    end
  endtask

  task automatic add_idle(input int n, input bit p, input bit t);
    repeat (n) push(1'b1, 1'b0, p, t);
  endtask

  task automatic add_low(input int n, input bit p, input bit t);
    repeat (n) push(1'b0, 1'b0, p, t);
  endtask

  task automatic add_rst(input int n);
    repeat (n) push(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic add_bit(input bit v, input bit p, input bit t);
    repeat (P) push(v, 1'b0, p, t);
  endtask

  task automatic add_frame(input logic [DW-1:0] d, input bit p, input bit t,
                           input bit flip, input bit stop, output int start);
    bit pb;
    start = len;
    add_bit(1'b0, p, t);
    for (int k = 0; k < DW; k++) add_bit(d[k], p, t);
    pb = (t ? ~^d : ^d) ^ flip;
    if (p) add_bit(pb, p, t);
    add_bit(stop, p, t);
  endtask

  // Line level as seen by the receiver logic at a posedge
  function automatic bit eff(input int c);
    if (c < SL || c - SL >= len) return 1'b1;
    for (int k = 1; k <= SL; k++) if (w_rst[c-k]) return 1'b1;
    return w_line[c-SL];
  endfunction

  function automatic bit bitval(input int t, input int k);
    int a, s;
    a = t + k * P + P / 2 - 1;
    s = int'(eff(a)) + int'(eff(a + 1)) + int'(eff(a + 2));
    return s >= 2;
  endfunction

  task automatic run_model();
    int t, d, nb, endc, ab;
    bit pf, tf, pbad, stp;
    logic [DW-1:0] dat, pd;
    for (int c = 0; c < MAXC; c++) begin
      e_dv[c] = 0; e_pe[c] = 0; e_se[c] = 0; e_dat[c] = '0; e_pd[c] = '0;
    end
    t = 0;
    while (t < len) begin
      if (w_rst[t] || eff(t)) begin t++; continue; end
      pf = w_pen[t]; tf = w_ptyp[t];
      nb = 2 + DW + int'(pf);
      d  = t + (nb - 1) * P + P / 2 + 1;
      endc = bitval(t, 0) ? t + P - 1 : d;
      ab = -1;
      for (int c = t + 1; c <= endc && c < len; c++) if (w_rst[c]) begin ab = c; break; end
      if (ab >= 0) begin t = ab + 1; continue; end
      if (endc >= len) break;
      if (bitval(t, 0)) begin t = t + P; continue; end
      for (int k = 0; k < DW; k++) dat[k] = bitval(t, k + 1);
      pbad = pf && (bitval(t, DW + 1) != (tf ? ~^dat : ^dat));
      stp  = bitval(t, nb - 1);
      e_pe[d] = pbad;
      e_se[d] = !stp;
      e_dv[d] = !pbad && stp;
      e_dat[d] = dat;
      m_events++;
      t = d + 1;
    end
    pd = '0;
    for (int c = 0; c < len; c++) begin
      if (w_rst[c]) pd = '0;
      else if (e_dv[c]) pd = e_dat[c];
      e_pd[c] = pd;
    end
  endtask

  task automatic check_ev(input string tag, input int cyc, input logic [2:0] kind, input logic [DW-1:0] pd);
    logic [2:0] k;
    logic [DW-1:0] p;
    k = 'x; p = 'x;
    foreach (q_cyc[i]) if (q_cyc[i] == cyc) begin k = q_kind[i]; p = q_pd[i]; end
    chk({tag, "_kind"}, 16'(k), 16'(kind));
    chk({tag, "_pdata"}, 16'(p), 16'(pd));
  endtask

  function automatic int count_ev(input int lo, input int hi);
    int n;
    n = 0;
    foreach (q_cyc[i]) if (q_cyc[i] >= lo && q_cyc[i] < hi) n++;
    return n;
  endfunction

  initial begin
    int t1, t2, t3, t4, t5, t6, t7, t8, t9, tr, gl;
    logic [DW-1:0] rd;
    bit rp, rt, rf, rs;

    add_rst(3);
    add_idle(10, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, t1); add_idle(12, 1'b0, 1'b0);
    add_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, t2); add_idle(12, 1'b1, 1'b0);
    add_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, t3); add_idle(12, 1'b1, 1'b1);
    add_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, t4); add_idle(12, 1'b0, 1'b0);
    t5 = len; add_low(3, 1'b0, 1'b0); add_idle(20, 1'b0, 1'b0);
    add_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, t6); add_idle(12, 1'b0, 1'b0);
    t7 = len; add_bit(1'b0, 1'b0, 1'b0);
    repeat (4) add_bit(1'b1, 1'b0, 1'b0);
    add_rst(2); add_idle(5, 1'b0, 1'b0);
    add_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, t8); add_idle(12, 1'b0, 1'b0);
    t9 = len; add_low(200, 1'b0, 1'b0); add_idle(40, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      rd = DW'($urandom); rp = 1'($urandom); rt = 1'($urandom);
      rf = ($urandom_range(0, 3) == 0); rs = ($urandom_range(0, 5) != 0);
      add_frame(rd, rp, rt, rf, rs, tr);
      add_idle($urandom_range(12, 20), rp, rt);
      if ($urandom_range(0, 4) == 0) begin
        gl = $urandom_range(1, 2);
        add_low(gl, rp, rt); add_idle(12, rp, rt);
      end
    end
    add_idle(20, 1'b0, 1'b0);
    run_model();

    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      rx = w_line[c]; rst = w_rst[c]; pen = w_pen[c]; ptyp = w_ptyp[c];
      @(posedge clk);
      #1;
      if (dv || pe || se) begin
        q_cyc.push_back(c + 1); q_kind.push_back({dv, pe, se}); q_pd.push_back(pdata);
      end
      chk($sformatf("dv@%0d", c + 1), 16'(dv), 16'(e_dv[c]));
      chk($sformatf("par_err@%0d", c + 1), 16'(pe), 16'(e_pe[c]));
      chk($sformatf("stp_err@%0d", c + 1), 16'(se), 16'(e_se[c]));
      chk($sformatf("p_data@%0d", c + 1), 16'(pdata), 16'(e_pd[c]));
    end

    check_ev("a5_nopar",    t1 + 78 + SL, 3'b100, 8'hA5);
    check_ev("3c_even",     t2 + 86 + SL, 3'b100, 8'h3C);
    check_ev("3c_odd_perr", t3 + 86 + SL, 3'b010, 8'h3C);
    check_ev("55_stop0",    t4 + 78 + SL, 3'b001, 8'h3C);
    chk("glitch_quiet", 16'(count_ev(t5, t6)), 16'd0);
    check_ev("12_after_glitch", t6 + 78 + SL, 3'b100, 8'h12);
    chk("reset_abort_quiet", 16'(count_ev(t7, t8)), 16'd0);
    check_ev("81_after_reset", t8 + 78 + SL, 3'b100, 8'h81);
    check_ev("break_first", t9 + 78 + SL, 3'b001, 8'h81);
    check_ev("break_repeat", t9 + 156 + SL, 3'b001, 8'h81);
    chk("event_total", 16'(q_cyc.size()), 16'(m_events));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_receiver.md
Name: uart_rx_frame_receiver

Overview:
- UART receive path, the counterpart of the transmit-side parity generator.
- Oversamples RX_IN, detects the start bit, shifts in DATA_WIDTH data bits LSB first, and optionally checks a parity bit (even/odd).
- Checks the stop bit and delivers a parallel word with a one-cycle valid pulse, or a one-cycle error flag.
- Sits between the serial pad and the command decoder of CREM.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..8).
- PRESCALE, 8, clk cycles per serial bit; even, >= 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- RX_IN  in  1  serial line; idle high.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd.
- P_DATA  out  DATA_WIDTH  last good received word.
- Data_Valid  out  1  one-cycle pulse; P_DATA updated.
- par_err  out  1  one-cycle pulse; parity mismatch.
- stp_err  out  1  one-cycle pulse; stop bit sampled 0.

Behaviour:
- Reset: synchronous, active-high.
  - All outputs 0, P_DATA = 0.
  - State IDLE, all counters 0.
  - Reset mid-frame discards the partial frame; no pulses are produced.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within each bit, then wraps.
  - bit_cnt counts 0..DATA_WIDTH-1 in DATA.
- Bit sampling:
  - Samples are taken at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the majority of the three, resolved on the PRESCALE/2+1 cycle (two samples registered, third taken live).
- IDLE: RX_IN == 0 at cycle T -> go to START. That cycle counts as edge 0; edge_cnt = 1 at T+1.
- PAR_EN and PAR_TYP are captured at T and held for the whole frame; mid-frame changes are ignored.
- START:
  - If the majority bit is 1 (glitch), return to IDLE at the end of the bit period with no outputs.
  - If the majority bit is 0, go to DATA at edge_cnt == PRESCALE-1.
- DATA:
  - Each majority bit is shifted in, LSB first.
  - After bit DATA_WIDTH-1 completes, go to PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected parity = ^data when PAR_TYP = 0, ~^data when PAR_TYP = 1.
  - Mismatch sets an internal error flag.
- STOP:
  - On the majority cycle, decide the frame result and go directly to IDLE (half bit early, so back-to-back frames are supported).
  - Registered outputs appear the next cycle.
  - No errors: Data_Valid = 1 and P_DATA is loaded.
  - Otherwise: par_err and/or stp_err = 1 (both may assert together); Data_Valid stays 0 and P_DATA holds its previous value.
- Latency:
  - N = 2 + DATA_WIDTH + PAR_EN.
  - Outputs pulse at T + (N-1)*PRESCALE + PRESCALE/2 + 2.
  - For defaults: T+78 without parity, T+86 with parity.
- Break condition (line held low):
  - The frame ends with stp_err.
  - IDLE then sees 0 immediately and starts a new frame, which repeats while the line stays low.
- Pulses are never longer than one cycle; no two frame results occur closer than (N-1)*PRESCALE cycles.

Optional Feature:
- Macro: UART_RX_INPUT_SYNC_EN.
- Defined:
  - RX_IN passes through a 2-flop synchronizer, reset to 1, before all logic.
  - All latencies grow by 2 cycles (T+80 / T+88 for defaults), measured from the RX_IN edge at the pin.
- Undefined: RX_IN is used directly; the source must already be synchronous to clk.

Test Plan:
- Frame 0xA5, PAR_EN = 0, start edge at T -> Data_Valid pulse at T+78, P_DATA = 0xA5, no error pulses.
- Frame 0x3C, PAR_EN = 1, PAR_TYP = 0, parity bit 0 -> Data_Valid at T+86, P_DATA = 0x3C.
- Frame 0x3C, PAR_EN = 1, PAR_TYP = 1, parity bit 0 -> par_err pulse at T+86, Data_Valid = 0, P_DATA keeps 0x3C from the previous frame.
- Frame 0x55 with stop bit driven 0 -> stp_err pulse at T+78, Data_Valid = 0.
- RX_IN low for 3 cycles, then high -> no output pulses; FSM back in IDLE by T+8; a following 0x12 frame is received correctly.
- rst asserted after 4 data bits of 0xFF, then frame 0x81 sent -> no pulse for the aborted frame; Data_Valid with P_DATA = 0x81.
